mem_arbiter: RTL and testbench

Shares the single-port datapath RAM (512 x 32, one-cycle synchronous read) between two requesters: the CPU memory path (MAR/MDR side, driven by the control unit) and a DMA/loader port used for program load and I/O block transfers. It sits between the requesters and the RAM's Read/Write/address/DataIn/DataOut pins. Each access is serialised through a small state machine. Fixed CPU priority applies, with a starvation guard that guarantees DMA progress.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_fair_ctr.sv | 30 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// The state enum, owner encodings and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_fair_ctr.sv
// Saturating count of CPU wins taken while DMA waits; force_dma at the limit.
// Updates on the grant edge, so force_dma applies to the next arbitration.
module mem_arb_fair_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_grant,
    input  logic dma_grant,
    input  logic dma_pending,
    output logic force_dma
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (dma_grant) begin
            starve_cnt <= '0;
        end else if (cpu_grant && dma_pending && (starve_cnt != CW'(MAX_WAIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_dma = (starve_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA accesses onto one single-port RAM; CPU priority with DMA starvation guard.
// Write: strobe +1, ack +2. Read: strobe +1, ack +2+RD_LAT. Requests stay pending until acked.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RD_LAT       = 1,
    parameter int DMA_MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int WCW = $clog2(RD_LAT + 1);

    arb_state_t        state, state_nxt;
    logic              lat_we;
    logic [WCW-1:0]    wait_cnt;
    logic              force_dma;
    logic              grant_cpu, grant_dma, grant;
    logic              wait_last;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              mem_read_nxt, mem_write_nxt, cpu_ack_nxt, dma_ack_nxt, busy_nxt;

    assign grant_dma = (state == IDLE) && dma_req && (!cpu_req || force_dma);
    assign grant_cpu = (state == IDLE) && cpu_req && !grant_dma;
    assign grant     = grant_cpu || grant_dma;
    assign sel_we    = grant_dma ? dma_we    : cpu_we;
    assign sel_addr  = grant_dma ? dma_addr  : cpu_addr;
    assign sel_wdata = grant_dma ? dma_wdata : cpu_wdata;
    assign wait_last = (wait_cnt == WCW'(RD_LAT - 1));

    mem_arb_fair_ctr #(.MAX_WAIT(DMA_MAX_WAIT)) u_fair (
        .clock       (clock),
        .reset       (reset),
        .cpu_grant   (grant_cpu),
        .dma_grant   (grant_dma),
        .dma_pending (dma_req),
        .force_dma   (force_dma)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= busy_nxt;
            mem_read  <= mem_read_nxt;
            mem_write <= mem_write_nxt;
            cpu_ack   <= cpu_ack_nxt;
            dma_ack   <= dma_ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_we ? DONE : WAIT;
            WAIT:    if (wait_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so their next values are decoded from the next state.
    always_comb begin
        mem_read_nxt  = grant && !sel_we;
        mem_write_nxt = grant && sel_we;
        busy_nxt      = (state_nxt != IDLE);
        cpu_ack_nxt   = (state_nxt == DONE) && (owner == OWN_CPU);
        dma_ack_nxt   = (state_nxt == DONE) && (owner == OWN_DMA);
    end

    // mem_addr/mem_wdata double as the latched request fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_we    <= 1'b0;
            owner     <= OWN_CPU;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            if (grant) begin
                lat_we    <= sel_we;
                owner     <= grant_dma;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == WAIT) && wait_last) begin
                if (owner == OWN_DMA) dma_rdata <= mem_rdata;
                else                  cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus random traffic
// checked every cycle against a transaction-level model (grant decision + cycle offsets).
module tb_mem_arbiter;

    localparam int AW     = 9;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;
    localparam int MAXW   = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_ack, dma_ack, mem_read, mem_write, busy, owner;

    int n_tests = 0;
    int n_fail  = 0;
    int dma_ack_cnt = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .DMA_MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    // RAM with one-cycle synchronous read
    logic [DW-1:0] ram [512] = '{default: '0};
    always @(posedge clock) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= ram[mem_addr];
    end

    // Reference model: one transaction at a time, outputs derived from the offset since grant.
    logic [DW-1:0] ref_mem [512] = '{default: '0};
    bit            m_active = 1'b0;
    bit            m_g, m_we;
    int            m_k, m_len, m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          e_busy, e_owner, e_read, e_write, e_cpu_ack, e_dma_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_cpu_rdata, e_dma_rdata;

    task automatic model_step();
        e_read = 1'b0; e_write = 1'b0; e_cpu_ack = 1'b0; e_dma_ack = 1'b0;
        if (reset) begin
            m_active = 1'b0; m_starve = 0;
            e_busy = 1'b0; e_owner = 1'b0; e_addr = '0; e_wdata = '0;
            e_cpu_rdata = '0; e_dma_rdata = '0;
        end else if (!m_active) begin
            e_busy = 1'b0;
            if (cpu_req || dma_req) begin
                m_g = dma_req && (!cpu_req || m_starve == MAXW);
                if (m_g) m_starve = 0;
                else if (dma_req && m_starve < MAXW) m_starve++;
                m_we    = m_g ? dma_we : cpu_we;
                m_addr  = m_g ? dma_addr : cpu_addr;
                m_wdata = m_g ? dma_wdata : cpu_wdata;
                if (m_we) ref_mem[m_addr] = m_wdata;
                m_len = m_we ? 2 : 2 + RD_LAT;
                m_k = 1; m_active = 1'b1;
                e_busy = 1'b1; e_owner = m_g; e_addr = m_addr; e_wdata = m_wdata;
                e_read = !m_we; e_write = m_we;
            end
        end else if (m_k == m_len) begin
            m_active = 1'b0; e_busy = 1'b0;
        end else begin
            m_k++;
            if (m_k == m_len) begin
                if (m_g) e_dma_ack = 1'b1; else e_cpu_ack = 1'b1;
                if (!m_we) begin
                    if (m_g) e_dma_rdata = ref_mem[m_addr];
                    else     e_cpu_rdata = ref_mem[m_addr];
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (dma_ack) dma_ack_cnt++;
        if (check_en) begin
            n_tests++;
            if ({busy, owner, mem_read, mem_write, mem_addr, mem_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata} !==
                {e_busy, e_owner, e_read, e_write, e_addr, e_wdata, e_cpu_ack, e_dma_ack, e_cpu_rdata, e_dma_rdata}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got busy=%b own=%b rd=%b wr=%b a=%h wd=%h ca=%b da=%b cr=%h dr=%h, want busy=%b own=%b rd=%b wr=%b a=%h wd=%h ca=%b da=%b cr=%h dr=%h",
                         $time, busy, owner, mem_read, mem_write, mem_addr, mem_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata,
                         e_busy, e_owner, e_read, e_write, e_addr, e_wdata, e_cpu_ack, e_dma_ack, e_cpu_rdata, e_dma_rdata);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic raise(input bit port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (port) begin dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1'b1; end
        else      begin cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; end
    endtask

    // Counts negedges until the port's ack; optionally drops its request in the ack cycle.
    task automatic wait_ack(input bit port, input bit drop, output int cyc, output int s_cyc,
                            output logic [AW-1:0] s_addr);
        cyc = -1; s_cyc = -1; s_addr = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if ((mem_read || mem_write) && s_cyc < 0) begin s_cyc = i; s_addr = mem_addr; end
            if (port ? dma_ack : cpu_ack) begin
                cyc = i;
                if (drop) begin if (port) dma_req = 1'b0; else cpu_req = 1'b0; end
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL ack_timeout port=%0d: got no ack want ack within 30 cycles", port);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [2:0] lo = 3'($urandom_range(0, 7));
        return ($urandom_range(0, 1) != 0) ? {6'h3F, lo} : {6'h00, lo};
    endfunction

    int c, s, cpu_n, ack0;
    logic [AW-1:0] sa;
    bit got;

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_acks", {cpu_ack, dma_ack}, 0);
        check("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
        check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        check_en = 1'b1;
        reset = 1'b0;

        // CPU write then read of 0x012
        @(negedge clock);
        raise(0, 1, 9'h012, 32'hDEADBEEF);
        wait_ack(0, 1, c, s, sa);
        check("wr_strobe_cycle", s, 1);
        check("wr_ack_cycle", c, 2);
        @(negedge clock);
        raise(0, 0, 9'h012, 32'h0);
        wait_ack(0, 1, c, s, sa);
        check("rd_strobe_cycle", s, 1);
        check("rd_ack_cycle", c, 3);
        check("rd_data", cpu_rdata, 32'hDEADBEEF);
        check("rd_no_dma_ack", dma_ack_cnt, 0);

        // Simultaneous requests, starve counter 0 -> 1 -> 0
        @(negedge clock);
        check("sim_starve0", dut.u_fair.starve_cnt, 0);
        raise(0, 0, 9'h012, 32'h0);
        raise(1, 1, 9'h020, 32'h12345678);
        wait_ack(0, 1, c, s, sa);
        check("sim_cpu_first", c, 3);
        check("sim_cpu_owner", owner, 0);
        check("sim_starve1", dut.u_fair.starve_cnt, 1);
        wait_ack(1, 1, c, s, sa);
        check("sim_dma_next", c, 3);
        check("sim_dma_owner", owner, 1);
        check("sim_starve2", dut.u_fair.starve_cnt, 0);

        // Starvation guard: both held high
        @(negedge clock);
        raise(0, 0, 9'h012, 32'h0);
        raise(1, 0, 9'h020, 32'h0);
        cpu_n = 0; got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clock);
            if (cpu_ack) cpu_n++;
            if (dma_ack) begin
                got = 1'b1;
                check("starve_dma_owner", owner, 1);
                check("starve_dma_data", dma_rdata, 32'h12345678);
                dma_req = 1'b0;
            end
        end
        check("starve_dma_granted", got, 1);
        check("starve_cpu_acks", cpu_n, MAXW);
        wait_ack(0, 1, c, s, sa);
        check("starve_cpu_regains", c, 4);
        check("starve_cpu_owner", owner, 0);

        // Address edge 0x1FF
        @(negedge clock);
        raise(1, 1, 9'h1FF, 32'h00000001);
        wait_ack(1, 1, c, s, sa);
        check("edge_dma_addr", sa, 9'h1FF);
        @(negedge clock);
        raise(0, 0, 9'h1FF, 32'h0);
        wait_ack(0, 1, c, s, sa);
        check("edge_cpu_addr", sa, 9'h1FF);
        check("edge_cpu_rdata", cpu_rdata, 32'h00000001);

        // Isolation: DMA read while CPU idle
        @(negedge clock);
        raise(0, 1, 9'h000, 32'hA5A5A5A5);
        wait_ack(0, 1, c, s, sa);
        @(negedge clock);
        ack0 = dma_ack_cnt;
        raise(1, 0, 9'h000, 32'h0);
        wait_ack(1, 1, c, s, sa);
        repeat (4) @(negedge clock);
        check("iso_dma_rdata", dma_rdata, 32'hA5A5A5A5);
        check("iso_cpu_rdata_kept", cpu_rdata, 32'h00000001);
        check("iso_one_ack", dma_ack_cnt - ack0, 1);

        // Reset during the WAIT cycle of a DMA read
        raise(1, 0, 9'h012, 32'h0);
        @(negedge clock);
        check("rst_mid_issue", mem_read, 1);
        @(negedge clock);
        check("rst_mid_wait_busy", busy, 1);
        ack0 = dma_ack_cnt;
        reset = 1'b1; dma_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rdata", dma_rdata, 0);
        check("rst_mid_read", mem_read, 0);
        repeat (4) @(negedge clock);
        check("rst_mid_no_ack", dma_ack_cnt - ack0, 0);
        raise(1, 0, 9'h012, 32'h0);
        wait_ack(1, 1, c, s, sa);
        check("rst_after_ack_cycle", c, 3);
        check("rst_after_rdata", dma_rdata, 32'hDEADBEEF);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge clock);
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
            end else begin
                if (cpu_req && cpu_ack) begin
                    if ($urandom_range(0, 3) != 0) cpu_req = 1'b0;
                end else if (!cpu_req && !cpu_ack && $urandom_range(0, 2) == 0) begin
                    raise(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
                end
                if (dma_req && dma_ack) begin
                    dma_req = 1'b0;
                end else if (!dma_req && !dma_ack && $urandom_range(0, 2) == 0) begin
                    raise(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
                end
            end
        end
        reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        repeat (8) @(negedge clock);
        check("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
